// File: rtl/fetch_redirect_unit.sv
// IF-stage PC register and IF/ID pipeline register; applies taken-branch redirects,
// holding a redirect that arrives during a freeze until the freeze lifts.
module fetch_redirect_unit #(
   parameter int unsigned         WORD_LEN = 32,
   parameter logic [WORD_LEN-1:0] RESET_PC = '0,
   parameter int unsigned         CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                brCond,
   input  logic [WORD_LEN-1:0] brTarget,
   input  logic [WORD_LEN-1:0] instr_in,
   output logic [WORD_LEN-1:0] pc,
   output logic [WORD_LEN-1:0] ifid_pc,
   output logic [WORD_LEN-1:0] ifid_instr,
   output logic                ifid_valid,
   output logic                redir_pending,
   output logic [CNT_W-1:0]    br_taken_cnt
);

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [WORD_LEN-1:0] pc_q, pc_d;
   logic [WORD_LEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [WORD_LEN-1:0] ifid_instr_q, ifid_instr_d;
   logic                ifid_valid_q, ifid_valid_d;
   logic [WORD_LEN-1:0] pend_tgt_q, pend_tgt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [WORD_LEN-1:0] tgt;
   logic [WORD_LEN-1:0] pc_plus4;
   logic [WORD_LEN-1:0] redirect_pc;
   logic                take;

   // The low two target bits are dropped so fetch stays word aligned.
   assign tgt      = brTarget & ~WORD_LEN'(3);
   assign pc_plus4 = pc_q + WORD_LEN'(4);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      pend_tgt_d   = pend_tgt_q;
      cnt_d        = cnt_q;
      take         = 1'b0;
      redirect_pc  = tgt;

      if (!freeze) begin
         if (brCond) begin
            take        = 1'b1;
            redirect_pc = tgt;
         end else if (state_q == PEND) begin
            take        = 1'b1;
            redirect_pc = pend_tgt_q;
         end else begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_plus4;
            ifid_instr_d = instr_in;
            ifid_valid_d = 1'b1;
         end
      end else if (brCond) begin
         // Latest redirect seen during the freeze wins.
         pend_tgt_d = tgt;
         state_d    = PEND;
      end

      // An applied redirect leaves one bubble in IF/ID (ifid_valid=0, instr=NOP).
      if (take) begin
         pc_d         = redirect_pc;
         ifid_pc_d    = '0;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
         state_d      = RUN;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= '0;
         ifid_valid_q <= 1'b0;
         pend_tgt_q   <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         pend_tgt_q   <= pend_tgt_d;
         cnt_q        <= cnt_d;
      end
   end

   assign pc            = pc_q;
   assign ifid_pc       = ifid_pc_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_valid    = ifid_valid_q;
   assign redir_pending = (state_q == PEND);
   assign br_taken_cnt  = cnt_q;

endmodule
